// File: rtl/dmem_pkg.sv
// dmem_responder shared types: funct3 size codes, FSM states,
// and the byte-lane mask helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = '0;
    case (f3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the MEM stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// Word-organised byte-enabled synchronous RAM with a registered
// read port; read returns the word as it was before the same-edge write.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable data-memory responder for the MEM stage.
// Optional macro DMEM_MISALIGN_TRAP_EN: fault misaligned H/W accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTES =
    33'(DEPTH_WORDS) * 33'd4;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;

  logic        accept;
  logic        is_h, is_w;
  logic        range_err, mis, fault;
  logic [1:0]  off;
  logic [3:0]  we;
  logic [31:0] wrep;
  logic [31:0] rd;

  logic        err_q, ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext;

  assign bus.req_ready = rst && (state == IDLE);
  assign accept = bus.req_valid && bus.req_ready;

  assign is_h = (bus.req_funct3[1:0] == 2'b01);
  assign is_w = (bus.req_funct3 == F3_W);
  assign range_err = {1'b0, bus.req_addr} >= BYTES;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (is_h && bus.req_addr[0]) ||
               (is_w && bus.req_addr[1:0] != 2'b00);
  assign off = bus.req_addr[1:0];
`else
  // Misaligned halfword/word accesses are aligned down.
  assign mis = 1'b0;
  assign off = is_w ? 2'b00 :
               is_h ? {bus.req_addr[1], 1'b0} :
               bus.req_addr[1:0];
`endif

  assign fault = !f3_legal(bus.req_funct3) ||
                 range_err || mis;

  assign we = (accept && bus.req_we && !fault) ?
              lane_mask(bus.req_funct3, off) : 4'b0000;

  always_comb begin
    wrep = bus.req_wdata;
    unique case (1'b1)
      bus.req_funct3[1:0] == 2'b00:
        wrep = {4{bus.req_wdata[7:0]}};
      bus.req_funct3[1:0] == 2'b01:
        wrep = {2{bus.req_wdata[15:0]}};
      default:
        wrep = bus.req_wdata;
    endcase
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .en    (accept),
    .we    (we),
    .idx   (bus.req_addr[AW+1:2]),
    .wdata (wrep),
    .rdata (rd)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      ld_q  <= 1'b0;
      f3_q  <= '0;
      off_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        err_q <= fault;
        ld_q  <= !bus.req_we;
        f3_q  <= bus.req_funct3;
        off_q <= off;
      end
    end
  end

  // Bank read register plus captured size/offset form the response.
  always_comb begin
    b   = rd[{off_q, 3'b000} +: 8];
    h   = off_q[1] ? rd[31:16] : rd[15:0];
    ext = '0;
    unique case (1'b1)
      f3_q == F3_B:  ext = {{24{b[7]}}, b};
      f3_q == F3_BU: ext = {24'd0, b};
      f3_q == F3_H:  ext = {{16{h[15]}}, h};
      f3_q == F3_HU: ext = {16'd0, h};
      f3_q == F3_W:  ext = rd;
      default:       ext = '0;
    endcase
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata =
    (bus.rsp_valid && ld_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table
// plus backpressure and reset sequences, scoreboard-checked.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  localparam logic [31:0] OOR = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic we,
                       input logic [31:0] addr,
                       input logic [2:0] f3,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wdata;
  endtask

  task automatic idle_req();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom);
    bus.req_wdata  = $urandom;
  endtask

  // Waits for rsp_valid; returns cycles counted from acceptance.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic txn(input string tag, input vec_t v);
    int n;
    exp_t e;
    @(negedge clk);
    drive(v.we, v.addr, v.f3, v.wdata);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{rdata: v.rdata, err: v.err});
    @(negedge clk);
    idle_req();
    wait_rsp(n);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    if (bus.rsp_valid) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({tag, "_retired"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_ready_again"},
          32'(bus.req_ready), 32'd1);
    end else begin
      sb.delete();
    end
  endtask

  task automatic add(input logic we, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] wd,
                     input logic [31:0] rd, input logic er);
    vt.push_back('{we: we, addr: a, f3: f3, wdata: wd,
                   rdata: rd, err: er});
  endtask

  initial begin
    int n;
    exp_t e;
    logic [31:0] held;

    add(1, 32'h10, F3_W, 32'hDEADBEEF, 0, 0);
    add(0, 32'h10, F3_W, 0, 32'hDEADBEEF, 0);
    add(1, 32'h13, F3_B, 32'h00000080, 0, 0);
    add(0, 32'h13, F3_B, 0, 32'hFFFFFF80, 0);
    add(0, 32'h13, F3_BU, 0, 32'h00000080, 0);
    add(0, 32'h10, F3_W, 0, 32'h80ADBEEF, 0);
    add(0, 32'h12, F3_H, 0, 32'hFFFF80AD, 0);
    add(0, 32'h12, F3_HU, 0, 32'h000080AD, 0);
    add(0, 32'h10, F3_H, 0, 32'hFFFFBEEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, 32'h11, F3_H, 0, 0, 1);
    add(0, 32'h12, F3_W, 0, 0, 1);
    add(1, 32'h17, F3_H, 32'hFFFF, 0, 1);
`else
    add(0, 32'h11, F3_H, 0, 32'hFFFFBEEF, 0);
    add(0, 32'h12, F3_W, 0, 32'h80ADBEEF, 0);
    add(1, 32'h17, F3_H, 32'h5566, 0, 0);
`endif
    add(1, 32'h14, F3_W, 32'h11223344, 0, 0);
    add(1, 32'h16, F3_H, 32'hAAAA1234, 0, 0);
    add(0, 32'h14, F3_W, 0, 32'h12343344, 0);
    add(1, 32'h15, F3_B, 32'hFFFFFF7F, 0, 0);
    add(0, 32'h15, F3_B, 0, 32'h0000007F, 0);
    add(0, 32'h14, F3_W, 0, 32'h12347F44, 0);
    add(1, 32'h0, F3_W, 32'hCAFEF00D, 0, 0);
    add(0, OOR, F3_W, 0, 0, 1);
    add(1, OOR, F3_W, 32'h55555555, 0, 1);
    add(0, 32'hFFFFFFFF, F3_B, 0, 0, 1);
    add(0, 32'h0, 3'b011, 0, 0, 1);
    add(1, 32'h0, 3'b111, 32'h0, 0, 1);
    add(1, 32'h1, 3'b110, 32'h0, 0, 1);
    add(0, 32'h0, F3_W, 0, 32'hCAFEF00D, 0);
    add(1, OOR - 4, F3_W, 32'h0BADF00D, 0, 0);
    add(0, OOR - 4, F3_W, 0, 32'h0BADF00D, 0);
    add(0, OOR - 1, F3_BU, 0, 32'h0000000B, 0);

    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    idle_req();
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    foreach (vt[i]) txn($sformatf("v%0d", i), vt[i]);

    // Backpressure: held response, blocked second request.
    @(negedge clk);
    drive(0, 32'h10, F3_W, 0);
    @(posedge clk);
    sb.push_back('{rdata: 32'h80ADBEEF, err: 1'b0});
    @(negedge clk);
    idle_req();
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'(LAT));
    e = sb.pop_front();
    held = bus.rsp_rdata;
    chk("bp_rdata", held, e.rdata);
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h10, F3_W, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k),
          32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d", k), bus.rsp_rdata, held);
      chk($sformatf("bp_noready%0d", k),
          32'(bus.req_ready), 32'd0);
    end
    idle_req();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_retired", 32'(bus.rsp_valid), 32'd0);
    txn("bp_verify", '{we: 0, addr: 32'h10, f3: F3_W,
        wdata: 0, rdata: 32'h80ADBEEF, err: 0});

    // Reset while waiting on a store.
    @(negedge clk);
    drive(1, 32'h20, F3_W, 32'h12345678);
    @(posedge clk);
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    idle_req();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rstw_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstw_valid_held", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ready_rel", 32'(bus.req_ready), 32'd1);
    txn("rstw_verify", '{we: 0, addr: 32'h20, f3: F3_W,
        wdata: 0, rdata: 32'h12345678, err: 0});

    // Reset while a response is presented.
    @(negedge clk);
    drive(0, 32'h20, F3_W, 0);
    @(posedge clk);
    @(negedge clk);
    idle_req();
    wait_rsp(n);
    chk("rstr_pre_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstr_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstr_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn("rstr_verify", '{we: 0, addr: 32'h20, f3: F3_HU,
        wdata: 0, rdata: 32'h00005678, err: 0});

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
